// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences M-mode trap entry and MRET return for the RV32IM core.
// Sequence: DRAIN outstanding memory access, FLUSH the pipeline, write the CSRs one
// per cycle, then hold a fetch redirect until it is accepted. Outputs are registered
// and follow the state they belong to. drain_timeout_o is the exception: it reports
// the give-up decision in the DRAIN cycle where that decision is made.
module trap_sequencer #(
   parameter int XLEN          = 32,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            trap_req_i,
   input  logic            trap_is_irq_i,
   input  logic [3:0]      trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_tval_i,
   input  logic [XLEN-1:0] trap_vector_i,
   input  logic            mret_req_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            mstatus_mie_i,
   input  logic            mstatus_mpie_i,
   input  logic            mem_busy_i,
   input  logic            redirect_ready_i,
   output logic            stall_o,
   output logic            flush_o,
   output logic            csr_we_o,
   output logic [11:0]     csr_addr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            busy_o,
   output logic            drain_timeout_o
);

   localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_DRAIN      = 3'd1,
      S_FLUSH      = 3'd2,
      S_WR_MEPC    = 3'd3,
      S_WR_MCAUSE  = 3'd4,
      S_WR_MTVAL   = 3'd5,
      S_WR_MSTATUS = 3'd6,
      S_REDIRECT   = 3'd7
   } state_t;

   // mcause layout: interrupt flag in the MSB, cause code in the low nibble.
   function automatic logic [XLEN-1:0] f_mcause(input logic irq, input logic [3:0] cause);
      return {irq, {(XLEN-5){1'b0}}, cause};
   endfunction

   // mstatus image with MPP fixed to machine mode; all other fields cleared.
   function automatic logic [XLEN-1:0] f_mstatus(input logic mpie_bit, input logic mie_bit);
      logic [XLEN-1:0] v;
      v        = {XLEN{1'b0}};
      v[12:11] = 2'b11;
      v[7]     = mpie_bit;
      v[3]     = mie_bit;
      return v;
   endfunction

   state_t            r_state;
   logic [CW-1:0]     r_drain_cnt;
   logic              r_is_mret;
   logic              r_is_irq;
   logic [3:0]        r_cause;
   logic [XLEN-3:0]   r_pc_hi;
   logic [XLEN-1:0]   r_tval;
   logic [XLEN-1:0]   r_target;   // trap vector or mepc, whichever this sequence returns to
   logic              r_ie;       // captured mie (trap) or mpie (mret)

   logic              r_stall;
   logic              r_flush;
   logic              r_csr_we;
   logic [11:0]       r_csr_addr;
   logic [XLEN-1:0]   r_csr_wdata;
   logic              r_redirect_valid;
   logic [XLEN-1:0]   r_redirect_pc;

   logic              w_drain_timeout;

   // Drain gives up when the last allowed DRAIN cycle still sees the memory busy.
   always_comb begin
      w_drain_timeout = 1'b0;
      if ((r_state == S_DRAIN) && mem_busy_i && (r_drain_cnt == DRAIN_LAST)) begin
         w_drain_timeout = 1'b1;
      end else begin
         w_drain_timeout = 1'b0;
      end
   end

   // Sequencer state, request capture and registered outputs for the upcoming state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state          <= S_IDLE;
         r_drain_cnt      <= {CW{1'b0}};
         r_is_mret        <= 1'b0;
         r_is_irq         <= 1'b0;
         r_cause          <= 4'd0;
         r_pc_hi          <= {(XLEN-2){1'b0}};
         r_tval           <= {XLEN{1'b0}};
         r_target         <= {XLEN{1'b0}};
         r_ie             <= 1'b0;
         r_stall          <= 1'b0;
         r_flush          <= 1'b0;
         r_csr_we         <= 1'b0;
         r_csr_addr       <= 12'h000;
         r_csr_wdata      <= {XLEN{1'b0}};
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= {XLEN{1'b0}};
      end else begin
         // Pulsed outputs drop unless the next state asserts them.
         r_flush     <= 1'b0;
         r_csr_we    <= 1'b0;
         r_csr_addr  <= 12'h000;
         r_csr_wdata <= {XLEN{1'b0}};

         case (r_state)
            S_IDLE: begin
               r_redirect_valid <= 1'b0;
               r_redirect_pc    <= {XLEN{1'b0}};
               r_drain_cnt      <= {CW{1'b0}};
               if (trap_req_i) begin
                  r_is_mret <= 1'b0;
                  r_is_irq  <= trap_is_irq_i;
                  r_cause   <= trap_cause_i;
                  r_pc_hi   <= trap_pc_i[XLEN-1:2];
                  r_tval    <= trap_tval_i;
                  r_target  <= trap_vector_i;
                  r_ie      <= mstatus_mie_i;
                  r_stall   <= 1'b1;
                  r_state   <= S_DRAIN;
               end else if (mret_req_i) begin
                  r_is_mret <= 1'b1;
                  r_target  <= mepc_i;
                  r_ie      <= mstatus_mpie_i;
                  r_stall   <= 1'b1;
                  r_state   <= S_DRAIN;
               end else begin
                  r_stall   <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end

            S_DRAIN: begin
               if (!mem_busy_i || w_drain_timeout) begin
                  r_flush <= 1'b1;
                  r_state <= S_FLUSH;
               end else begin
                  r_drain_cnt <= r_drain_cnt + CNT_ONE;
               end
            end

            S_FLUSH: begin
               r_csr_we <= 1'b1;
               if (r_is_mret) begin
                  r_csr_addr  <= CSR_MSTATUS;
                  r_csr_wdata <= f_mstatus(1'b1, r_ie);
                  r_state     <= S_WR_MSTATUS;
               end else begin
                  r_csr_addr  <= CSR_MEPC;
                  r_csr_wdata <= {r_pc_hi, 2'b00};
                  r_state     <= S_WR_MEPC;
               end
            end

            S_WR_MEPC: begin
               r_csr_we    <= 1'b1;
               r_csr_addr  <= CSR_MCAUSE;
               r_csr_wdata <= f_mcause(r_is_irq, r_cause);
               r_state     <= S_WR_MCAUSE;
            end

            S_WR_MCAUSE: begin
               r_csr_we    <= 1'b1;
               r_csr_addr  <= CSR_MTVAL;
               r_csr_wdata <= r_is_irq ? {XLEN{1'b0}} : r_tval;
               r_state     <= S_WR_MTVAL;
            end

            S_WR_MTVAL: begin
               r_csr_we    <= 1'b1;
               r_csr_addr  <= CSR_MSTATUS;
               r_csr_wdata <= f_mstatus(r_ie, 1'b0);
               r_state     <= S_WR_MSTATUS;
            end

            S_WR_MSTATUS: begin
               r_redirect_valid <= 1'b1;
               r_redirect_pc    <= r_target;
               r_state          <= S_REDIRECT;
            end

            S_REDIRECT: begin
               if (redirect_ready_i) begin
                  r_redirect_valid <= 1'b0;
                  r_redirect_pc    <= {XLEN{1'b0}};
                  r_stall          <= 1'b0;
                  r_state          <= S_IDLE;
               end else begin
                  r_redirect_valid <= 1'b1;
                  r_redirect_pc    <= r_target;
                  r_state          <= S_REDIRECT;
               end
            end

            default: begin
               r_stall          <= 1'b0;
               r_redirect_valid <= 1'b0;
               r_redirect_pc    <= {XLEN{1'b0}};
               r_state          <= S_IDLE;
            end
         endcase
      end
   end

   assign stall_o          = r_stall;
   assign flush_o          = r_flush;
   assign csr_we_o         = r_csr_we;
   assign csr_addr_o       = r_csr_addr;
   assign csr_wdata_o      = r_csr_wdata;
   assign redirect_valid_o = r_redirect_valid;
   assign redirect_pc_o    = r_redirect_pc;
   assign busy_o           = (r_state != S_IDLE);
   assign drain_timeout_o  = w_drain_timeout;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: each transaction is expanded from the sequence rules into
// a per-cycle list of expected outputs and driven inputs, then replayed cycle by cycle.
module tb_trap_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        trap_req_i, trap_is_irq_i, mret_req_i;
   logic [3:0]  trap_cause_i;
   logic [31:0] trap_pc_i, trap_tval_i, trap_vector_i, mepc_i;
   logic        mstatus_mie_i, mstatus_mpie_i, mem_busy_i, redirect_ready_i;
   logic        stall_o, flush_o, csr_we_o, redirect_valid_o, busy_o, drain_timeout_o;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_wdata_o, redirect_pc_o;

   int n_checks = 0;
   int n_fail   = 0;
   int txn_id   = 0;

   typedef struct packed {
      logic        stall;
      logic        flush;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        rv;
      logic [31:0] rpc;
      logic        tmo;
      logic        mb;
      logic        rdy;
   } cyc_t;

   trap_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .trap_req_i(trap_req_i), .trap_is_irq_i(trap_is_irq_i), .trap_cause_i(trap_cause_i),
      .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .trap_vector_i(trap_vector_i),
      .mret_req_i(mret_req_i), .mepc_i(mepc_i),
      .mstatus_mie_i(mstatus_mie_i), .mstatus_mpie_i(mstatus_mpie_i),
      .mem_busy_i(mem_busy_i), .redirect_ready_i(redirect_ready_i),
      .stall_o(stall_o), .flush_o(flush_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
      .csr_wdata_o(csr_wdata_o), .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o), .busy_o(busy_o), .drain_timeout_o(drain_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic cyc_t mk(input logic stall, input logic flush, input logic we,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic rv, input logic [31:0] rpc, input logic tmo,
                               input logic mb, input logic rdy);
      cyc_t c;
      c = {stall, flush, we, addr, wdata, rv, rpc, tmo, mb, rdy};
      return c;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Compare every observable output against one expected cycle record.
   task automatic check_cycle(input string where, input cyc_t e);
      check_value({where, " ctrl"},
                  {58'd0, stall_o, flush_o, csr_we_o, redirect_valid_o, busy_o, drain_timeout_o},
                  {58'd0, e.stall, e.flush, e.we, e.rv, e.stall, e.tmo});
      check_value({where, " csr"}, {20'd0, csr_addr_o, csr_wdata_o}, {20'd0, e.addr, e.wdata});
      check_value({where, " rpc"}, {32'd0, redirect_pc_o}, {32'd0, e.rpc});
   endtask

   task automatic scramble_inputs();
      trap_req_i     = rbit();
      mret_req_i     = rbit();
      trap_is_irq_i  = rbit();
      trap_cause_i   = 4'($urandom);
      trap_pc_i      = $urandom;
      trap_tval_i    = $urandom;
      trap_vector_i  = $urandom;
      mepc_i         = $urandom;
      mstatus_mie_i  = rbit();
      mstatus_mpie_i = rbit();
   endtask

   task automatic run_txn(input bit do_trap, input bit do_mret, input int busy_n,
                          input bit stuck, input int rdy_delay, input logic irq,
                          input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                          input logic [31:0] vec, input logic [31:0] mepc,
                          input logic mie, input logic mpie);
      cyc_t        q[$];
      cyc_t        idle;
      logic [31:0] tgt;
      int          cyc;
      idle = mk(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 32'd0, 1'b0, rbit(), rbit());
      tgt  = do_trap ? vec : mepc;
      // Drain phase: either the memory goes quiet after busy_n cycles or it never does.
      if (stuck) begin
         for (int k = 0; k < 16; k++)
            q.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 32'd0, (k == 15), 1'b1, rbit()));
      end else begin
         for (int k = 0; k <= busy_n; k++)
            q.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 32'd0, 1'b0, (k < busy_n), rbit()));
      end
      q.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 32'd0, 1'b0, 32'd0, 1'b0, rbit(), rbit()));
      if (do_trap) begin
         q.push_back(mk(1'b1, 1'b0, 1'b1, 12'h341, pc & 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, rbit(), rbit()));
         q.push_back(mk(1'b1, 1'b0, 1'b1, 12'h342, ({31'd0, irq} << 31) | {28'd0, cause},
                        1'b0, 32'd0, 1'b0, rbit(), rbit()));
         q.push_back(mk(1'b1, 1'b0, 1'b1, 12'h343, irq ? 32'd0 : tval, 1'b0, 32'd0, 1'b0, rbit(), rbit()));
         q.push_back(mk(1'b1, 1'b0, 1'b1, 12'h300, 32'h1800 + (mie ? 32'h80 : 32'h0),
                        1'b0, 32'd0, 1'b0, rbit(), rbit()));
      end else begin
         q.push_back(mk(1'b1, 1'b0, 1'b1, 12'h300, 32'h1880 + (mpie ? 32'h8 : 32'h0),
                        1'b0, 32'd0, 1'b0, rbit(), rbit()));
      end
      for (int k = 0; k <= rdy_delay; k++)
         q.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, tgt, 1'b0, rbit(), (k == rdy_delay)));

      // Acceptance cycle: the DUT is idle and samples the request at the end of it.
      @(negedge clk_i);
      trap_req_i = do_trap; mret_req_i = do_mret; trap_is_irq_i = irq; trap_cause_i = cause;
      trap_pc_i = pc; trap_tval_i = tval; trap_vector_i = vec; mepc_i = mepc;
      mstatus_mie_i = mie; mstatus_mpie_i = mpie;
      mem_busy_i = idle.mb; redirect_ready_i = idle.rdy;
      #1 check_cycle($sformatf("t%0d c0", txn_id), idle);
      cyc = 1;
      // Busy cycles: requests and data toggle freely and must be ignored.
      while (q.size() > 0) begin
         cyc_t e;
         e = q.pop_front();
         @(negedge clk_i);
         scramble_inputs();
         mem_busy_i = e.mb; redirect_ready_i = e.rdy;
         #1 check_cycle($sformatf("t%0d c%0d", txn_id, cyc), e);
         cyc++;
      end
      @(negedge clk_i);
      trap_req_i = 1'b0; mret_req_i = 1'b0;
      mem_busy_i = rbit(); redirect_ready_i = rbit();
      #1 check_cycle($sformatf("t%0d c%0d idle", txn_id, cyc), idle);
      txn_id++;
   endtask

   // Reset asserted mid-sequence (during the mcause write) must clear everything at once.
   task automatic run_reset_mid();
      cyc_t zero;
      zero = '0;
      @(negedge clk_i);
      trap_req_i = 1'b1; mret_req_i = 1'b0; trap_is_irq_i = 1'b0; trap_cause_i = 4'd5;
      trap_pc_i = 32'h0000_3000; trap_tval_i = 32'h55; trap_vector_i = 32'h8000_0000;
      mem_busy_i = 1'b0; redirect_ready_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_i);
         trap_req_i = 1'b0;
      end
      #1 check_value("rst pre mcause", {52'd0, csr_we_o, csr_addr_o}, {52'd0, 1'b1, 12'h342});
      rst_ni = 1'b0;
      #1 check_cycle("rst asserted", zero);
      @(negedge clk_i);
      #1 check_cycle("rst held", zero);
      rst_ni = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         #1 check_cycle($sformatf("rst after %0d", k), zero);
      end
   endtask

   initial begin
      cyc_t zero;
      zero = '0;
      rst_ni = 1'b0;
      trap_req_i = 1'b0; mret_req_i = 1'b0; trap_is_irq_i = 1'b0; trap_cause_i = 4'd0;
      trap_pc_i = 32'd0; trap_tval_i = 32'd0; trap_vector_i = 32'd0; mepc_i = 32'd0;
      mstatus_mie_i = 1'b0; mstatus_mpie_i = 1'b0; mem_busy_i = 1'b0; redirect_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #1 check_cycle("reset", zero);
      rst_ni = 1'b1;

      // Directed cases.
      run_txn(1, 0, 0, 0, 0, 1'b0, 4'd2, 32'h0000_1006, 32'hDEAD_BEEF, 32'h8000_0100, 32'h0, 1'b1, 1'b0);
      run_txn(1, 0, 0, 0, 0, 1'b1, 4'd7, 32'h0000_0400, 32'h0000_1234, 32'h8000_0200, 32'h0, 1'b0, 1'b1);
      run_txn(1, 0, 3, 0, 0, 1'b0, 4'd4, 32'h0000_0808, 32'h0000_00AA, 32'h8000_0004, 32'h0, 1'b1, 1'b0);
      run_txn(1, 0, 0, 1, 1, 1'b0, 4'd6, 32'h0000_0C0F, 32'h0000_0BBB, 32'h8000_0010, 32'h0, 1'b0, 1'b0);
      run_txn(0, 1, 0, 0, 0, 1'b0, 4'd0, 32'h0,        32'h0,        32'h0,        32'h0000_2000, 1'b0, 1'b1);
      run_txn(0, 1, 2, 0, 0, 1'b1, 4'd3, 32'h0,        32'h0,        32'h0,        32'h0000_3004, 1'b1, 1'b0);
      run_txn(1, 1, 0, 0, 5, 1'b0, 4'd11, 32'h0000_4002, 32'h0000_0077, 32'h8000_0040, 32'h0000_5000, 1'b1, 1'b1);
      run_reset_mid();

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         bit dt, dm;
         dt = rbit();
         dm = dt ? rbit() : 1'b1;
         run_txn(dt, dm, $urandom_range(0, 5), ($urandom_range(0, 5) == 0), $urandom_range(0, 4),
                 rbit(), 4'($urandom), $urandom, $urandom, $urandom, $urandom, rbit(), rbit());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
